// File: rtl/card_mem_pkg.sv
// rtl/card_mem_pkg.sv - card node word layout shared by the card memory blocks
package card_mem_pkg;

  localparam int NODE_W    = 32;
  localparam int ADDR_W    = 10;

  localparam int ALLOC_BIT = 31;
  localparam int VALUE_MSB = 30;
  localparam int VALUE_LSB = 27;
  localparam int SUIT_MSB  = 26;
  localparam int SUIT_LSB  = 25;
  localparam int NEXT_MSB  = 9;
  localparam int NEXT_LSB  = 0;

  localparam logic [ADDR_W-1:0] NULL_ADDR = 10'd0;
  localparam logic [NODE_W-1:0] FREE_WORD = 32'h0000_0000;

endpackage

// File: rtl/free_card_list.sv
// rtl/free_card_list.sv - walks a card list from head and frees every node
// optional FREE_CARD_LIST_DOUBLE_FREE_CHECK_EN aborts the walk on an already free node
import card_mem_pkg::*;

module free_card_list #(
  parameter int RAM_RD_LAT = 1,
  parameter int MAX_NODES  = 52
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  head,
  output logic        finished_freeing,
  output logic [5:0]  freed_count,
  output logic        err_double_free,
  output logic        err_overrun,
  output logic [9:0]  ram_address,
  output logic        ram_clock,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [1:0] LAT_LOAD = 2'(RAM_RD_LAT);
  localparam logic [5:0] MAX_CNT  = 6'(MAX_NODES);

  state_t                state;
  logic [ADDR_W-1:0]     cur_addr;
  logic [ADDR_W-1:0]     next_addr;
  logic [1:0]            lat_cnt;
  logic                  en_prev;
  logic                  start_req;
  logic                  unused_q;

  assign ram_clock = clock;
  assign ram_data  = FREE_WORD;

`ifdef FREE_CARD_LIST_DOUBLE_FREE_CHECK_EN
  assign unused_q = ^ram_q[30:10];
`else
  assign unused_q = ^ram_q[31:10];
  assign err_double_free = 1'b0;
`endif

  // The address is presented on entry to READ, so READ plus WAIT span
  // exactly RAM_RD_LAT cycles before CHECK samples ram_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      finished_freeing <= 1'b0;
      freed_count      <= 6'd0;
      err_overrun      <= 1'b0;
`ifdef FREE_CARD_LIST_DOUBLE_FREE_CHECK_EN
      err_double_free  <= 1'b0;
`endif
      ram_wren         <= 1'b0;
      ram_address      <= NULL_ADDR;
      cur_addr         <= NULL_ADDR;
      next_addr        <= NULL_ADDR;
      lat_cnt          <= 2'd0;
      en_prev          <= 1'b1;
      start_req        <= 1'b0;
    end else begin
      en_prev   <= enable;
      start_req <= enable & ~en_prev;

      case (state)
        S_IDLE, S_DONE: begin
          if (start_req) begin
            freed_count      <= 6'd0;
            err_overrun      <= 1'b0;
`ifdef FREE_CARD_LIST_DOUBLE_FREE_CHECK_EN
            err_double_free  <= 1'b0;
`endif
            cur_addr         <= head;
            ram_address      <= head;
            lat_cnt          <= LAT_LOAD;
            if (head == NULL_ADDR) begin
              finished_freeing <= 1'b1;
              state            <= S_DONE;
            end else begin
              finished_freeing <= 1'b0;
              state            <= S_READ;
            end
          end
        end

        S_READ, S_WAIT: begin
          ram_address <= cur_addr;
          ram_wren    <= 1'b0;
          lat_cnt     <= lat_cnt - 2'd1;
          state       <= (lat_cnt == 2'd1) ? S_CHECK : S_WAIT;
        end

        S_CHECK: begin
          next_addr <= ram_q[NEXT_MSB:NEXT_LSB];
`ifdef FREE_CARD_LIST_DOUBLE_FREE_CHECK_EN
          if (!ram_q[ALLOC_BIT]) begin
            err_double_free  <= 1'b1;
            finished_freeing <= 1'b1;
            state            <= S_DONE;
          end else begin
            ram_wren <= 1'b1;
            state    <= S_WRITE;
          end
`else
          ram_wren <= 1'b1;
          state    <= S_WRITE;
`endif
        end

        S_WRITE: begin
          ram_wren    <= 1'b0;
          freed_count <= freed_count + 6'd1;
          state       <= S_NEXT;
        end

        S_NEXT: begin
          ram_wren <= 1'b0;
          if (next_addr == NULL_ADDR) begin
            finished_freeing <= 1'b1;
            state            <= S_DONE;
          end else if (freed_count == MAX_CNT) begin
            err_overrun      <= 1'b1;
            finished_freeing <= 1'b1;
            state            <= S_DONE;
          end else begin
            cur_addr    <= next_addr;
            ram_address <= next_addr;
            lat_cnt     <= LAT_LOAD;
            state       <= S_READ;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_free_card_list.sv
// tb/tb_free_card_list.sv - scoreboard bench for free_card_list
module tb_free_card_list;

  localparam int LAT  = 1;
  localparam int MAXN = 4;
`ifdef FREE_CARD_LIST_DOUBLE_FREE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [9:0]  head = 10'd0;
  logic        finished_freeing;
  logic [5:0]  freed_count;
  logic        err_double_free;
  logic        err_overrun;
  logic [9:0]  ram_address;
  logic        ram_clock;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;

  logic [31:0] mem  [1024];
  logic [31:0] pipe [LAT];
  logic        tb_clr = 1'b0;
  logic        tb_we  = 1'b0;
  logic [9:0]  tb_wa  = 10'd0;
  logic [31:0] tb_wd  = 32'd0;

  logic [31:0] wq [$];
  int n_checks = 0;
  int n_errors = 0;

  free_card_list #(.RAM_RD_LAT(LAT), .MAX_NODES(MAXN)) dut (
    .clock(clock), .reset(reset), .enable(enable), .head(head),
    .finished_freeing(finished_freeing), .freed_count(freed_count),
    .err_double_free(err_double_free), .err_overrun(err_overrun),
    .ram_address(ram_address), .ram_clock(ram_clock), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (tb_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
    end else if (tb_we) begin
      mem[tb_wa] <= tb_wd;
    end else if (ram_wren) begin
      mem[ram_address] <= ram_data;
    end
    pipe[0] <= mem[ram_address];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[LAT-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // every write the DUT issues must match the next address the model freed
  always @(negedge clock) begin
    if (!reset && ram_wren) begin
      if (wq.size() == 0) begin
        check_eq("unexpected_wren", 32'(ram_wren), 32'd0);
      end else begin
        automatic logic [31:0] e = wq.pop_front();
        check_eq("wr_addr", 32'(ram_address), e);
        check_eq("wr_data", ram_data, 32'd0);
      end
    end
  end

  task automatic clear_mem();
    @(negedge clock) tb_clr = 1'b1;
    @(negedge clock) tb_clr = 1'b0;
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] w);
    @(negedge clock);
    tb_we = 1'b1; tb_wa = a; tb_wd = w;
    @(negedge clock) tb_we = 1'b0;
  endtask

  function automatic logic [31:0] node(input logic alloc, input logic [9:0] nxt);
    logic [3:0] v;
    logic [1:0] s;
    v = 4'($urandom_range(1, 13));
    s = 2'($urandom_range(0, 3));
    return {alloc, v, s, 15'd0, nxt};
  endfunction

  // reference walk over a snapshot of the memory
  task automatic model(input logic [9:0] h, output int cnt, output int fin,
                       output logic dbl, output logic ovr);
    logic [31:0] m [1024];
    logic [31:0] w;
    logic [9:0]  a;
    bit stop;
    m = mem;
    cnt = 0; dbl = 1'b0; ovr = 1'b0; a = h; stop = (h == 10'd0);
    while (!stop) begin
      w = m[a];
      if (CHK && !w[31]) begin
        dbl = 1'b1; stop = 1;
      end else begin
        wq.push_back(32'(a));
        m[a] = 32'd0;
        cnt++;
        if (w[9:0] == 10'd0) stop = 1;
        else if (cnt == MAXN) begin ovr = 1'b1; stop = 1; end
        else a = w[9:0];
      end
    end
    fin = 1 + cnt * (3 + LAT) + (dbl ? LAT + 1 : 0);
  endtask

  task automatic run_walk(input string tag, input logic [9:0] h, input bit repulse);
    int exp_cnt, exp_fin, n;
    logic exp_dbl, exp_ovr;
    bit seen;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    model(h, exp_cnt, exp_fin, exp_dbl, exp_ovr);
    head = h;
    enable = 1'b1;
    @(posedge clock);
    n = 0; seen = 0;
    while (!seen && n < 400) begin
      @(posedge clock); #1;
      n++;
      if (finished_freeing) seen = 1;
      if (repulse && n == 3) enable = 1'b0;
      if (repulse && n == 4) enable = 1'b1;
    end
    check_eq({tag, "_fin_edge"}, 32'(n), 32'(exp_fin));
    repeat (2) @(posedge clock);
    #1;
    check_eq({tag, "_count"}, 32'(freed_count), 32'(exp_cnt));
    check_eq({tag, "_err_df"}, 32'(err_double_free), 32'(exp_dbl));
    check_eq({tag, "_err_ovr"}, 32'(err_overrun), 32'(exp_ovr));
    check_eq({tag, "_pending_wr"}, 32'(wq.size()), 32'd0);
    if (repulse) begin
      repeat (20) @(posedge clock);
      #1;
      check_eq({tag, "_hold_fin"}, 32'(finished_freeing), 32'd1);
      check_eq({tag, "_hold_cnt"}, 32'(freed_count), 32'(exp_cnt));
    end
  endtask

  initial begin
    logic [31:0] w40, w60;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_fin", 32'(finished_freeing), 32'd0);
    check_eq("rst_cnt", 32'(freed_count), 32'd0);
    check_eq("rst_err_df", 32'(err_double_free), 32'd0);
    check_eq("rst_err_ovr", 32'(err_overrun), 32'd0);
    check_eq("rst_wren", 32'(ram_wren), 32'd0);
    check_eq("rst_addr", 32'(ram_address), 32'd0);
    check_eq("ram_clock", 32'(ram_clock), 32'(clock));
    @(negedge clock) reset = 1'b0;
    clear_mem();

    run_walk("null", 10'd0, 1'b0);

    clear_mem();
    poke(10'h020, node(1'b1, 10'h040));
    poke(10'h040, node(1'b1, 10'h060));
    poke(10'h060, node(1'b1, 10'h000));
    poke(10'h021, 32'hdead_beef);
    run_walk("list3", 10'h020, 1'b0);
    check_eq("list3_mem20", mem[10'h020], 32'd0);
    check_eq("list3_mem40", mem[10'h040], 32'd0);
    check_eq("list3_mem60", mem[10'h060], 32'd0);
    check_eq("list3_mem21", mem[10'h021], 32'hdead_beef);

    clear_mem();
    poke(10'h020, node(1'b1, 10'h040));
    poke(10'h040, node(1'b0, 10'h000));
    run_walk("dfree", 10'h020, 1'b0);

    clear_mem();
    poke(10'h020, node(1'b1, 10'h040));
    poke(10'h040, node(1'b1, 10'h020));
    run_walk("cycle", 10'h020, 1'b0);

    clear_mem();
    poke(10'h100, node(1'b1, 10'h101));
    poke(10'h101, node(1'b1, 10'h102));
    poke(10'h102, node(1'b1, 10'h103));
    poke(10'h103, node(1'b1, 10'h000));
    run_walk("max_exact", 10'h100, 1'b0);

    clear_mem();
    w40 = node(1'b1, 10'h060);
    w60 = node(1'b1, 10'h000);
    poke(10'h020, node(1'b1, 10'h040));
    poke(10'h040, w40);
    poke(10'h060, w60);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    wq.push_back(32'h020);
    head = 10'h020;
    enable = 1'b1;
    @(posedge clock);
    repeat (6) @(posedge clock);
    #1;
    check_eq("rst_mid_pre_cnt", 32'(freed_count), 32'd1);
    check_eq("rst_mid_pre_wren", 32'(ram_wren), 32'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    check_eq("rst_mid_wren", 32'(ram_wren), 32'd0);
    check_eq("rst_mid_addr", 32'(ram_address), 32'd0);
    check_eq("rst_mid_cnt", 32'(freed_count), 32'd0);
    check_eq("rst_mid_fin", 32'(finished_freeing), 32'd0);
    @(negedge clock) reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_mid_mem20", mem[10'h020], 32'd0);
    check_eq("rst_mid_mem40", mem[10'h040], w40);
    check_eq("rst_mid_mem60", mem[10'h060], w60);
    check_eq("rst_mid_pending", 32'(wq.size()), 32'd0);

    clear_mem();
    poke(10'h030, node(1'b1, 10'h031));
    poke(10'h031, node(1'b1, 10'h032));
    poke(10'h032, node(1'b1, 10'h000));
    run_walk("repulse", 10'h030, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
